// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch front end.
//   fetch_state_e : controller state, encoded as it appears on state_o
//   NOP_INSTR     : addi x0,x0,0, used to fill IF/ID on a bubble
//   fetch_pkt_t   : one fetched instruction with its PC and a valid flag
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        REDIR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller and a synchronous IMEM.
//   imem_en    : read enable for this cycle
//   pc         : read address for this cycle
//   imem_instr : read data for the address issued in the previous cycle
// master = fetch controller, slave = memory.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_en;
    logic [XLEN-1:0] pc;
    logic [31:0]     imem_instr;

    modport master (output imem_en, output pc, input imem_instr);
    modport slave  (input imem_en, input pc, output imem_instr);
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching the IMEM response that lands while fetch
// is held.
//   clk, rst : clock, synchronous active-high reset
//   push_i   : capture pkt_i
//   pop_i    : release the held entry
//   clear_i  : drop the held entry (wins over push and pop)
//   pkt_i    : packet to capture
//   pkt_o    : held packet; valid is forced low while empty
//   full_o   : an entry is held
module fetch_skid
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       clear_i,
    input  fetch_pkt_t pkt_i,
    output fetch_pkt_t pkt_o,
    output logic       full_o
);

    logic       full_q, full_d;
    fetch_pkt_t pkt_q, pkt_d;

    always_comb begin
        full_d = full_q;
        pkt_d  = pkt_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d = 1'b1;
            pkt_d  = pkt_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            pkt_q  <= '0;
        end else begin
            full_q <= full_d;
            pkt_q  <= pkt_d;
        end
    end

    always_comb begin
        pkt_o       = pkt_q;
        pkt_o.valid = pkt_q.valid & full_q;
    end

    assign full_o = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch controller: owns the PC, the IMEM request, a one-entry
// skid buffer and the IF/ID register, and turns hazard-unit stall/flush
// requests into fetch holds, redirects and ID/EX bubbles.
//   clk, rst        : clock, synchronous active-high reset
//   stall_req_i     : load-use hold request
//   flush_req_i     : redirect request (wins over stall)
//   flush_target_i  : redirect address
//   imem            : IMEM bus (enable, address, 1-cycle-latency data)
//   ifid_pc_o/ifid_instr_o/ifid_valid_o : IF/ID register
//   ex_bubble_o     : ID/EX must capture a bubble this cycle
//   state_o         : RUN=0, STALL=1, REDIR=2
//   stall_cnt_o/flush_cnt_o : saturating event counters
module fetch_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int              PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_req_i,
    input  logic              flush_req_i,
    input  logic [XLEN-1:0]   flush_target_i,
    fetch_ctrl_if.master      imem,
    output logic [XLEN-1:0]   ifid_pc_o,
    output logic [31:0]       ifid_instr_o,
    output logic              ifid_valid_o,
    output logic              ex_bubble_o,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    pipe_pkg::fetch_state_e state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              fetch_vld_q, fetch_vld_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    logic                 skid_push, skid_pop, skid_clear, skid_full;
    pipe_pkg::fetch_pkt_t resp_pkt, skid_pkt, src_pkt;

    // The response arriving this cycle belongs to the address issued last cycle.
    always_comb begin
        resp_pkt.pc    = fetch_pc_q;
        resp_pkt.instr = imem.imem_instr;
        resp_pkt.valid = fetch_vld_q;
    end

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .clear_i (skid_clear),
        .pkt_i   (resp_pkt),
        .pkt_o   (skid_pkt),
        .full_o  (skid_full)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        fetch_vld_d  = fetch_vld_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        skid_push    = 1'b0;
        skid_pop     = 1'b0;
        skid_clear   = 1'b0;
        src_pkt      = resp_pkt;

        if (flush_req_i) begin
            // Redirect: drop everything in flight, target goes out next cycle.
            pc_d         = flush_target_i;
            fetch_vld_d  = 1'b0;
            skid_clear   = 1'b1;
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            state_d      = pipe_pkg::REDIR;
            flush_cnt_d  = sat_inc(flush_cnt_q);
        end else if (stall_req_i) begin
            // Only the stall-onset cycle can have a response in flight,
            // because no new address is issued while stalled.
            if (fetch_vld_q && !skid_full) begin
                skid_push = 1'b1;
            end
            fetch_vld_d = 1'b0;
            state_d     = pipe_pkg::STALL;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            pc_d        = pc_q + XLEN'(4);
            fetch_pc_d  = pc_q;
            fetch_vld_d = 1'b1;
            // A held entry is older than anything on the IMEM bus.
            if (skid_full) begin
                skid_pop = 1'b1;
                src_pkt  = skid_pkt;
            end
            if (src_pkt.valid) begin
                ifid_pc_d    = src_pkt.pc;
                ifid_instr_d = src_pkt.instr;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_pc_d    = '0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            state_d = pipe_pkg::RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= pipe_pkg::REDIR;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= '0;
            fetch_vld_q  <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            fetch_vld_q  <= fetch_vld_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_bubble_o  = rst | flush_req_i | stall_req_i;
    assign imem.imem_en = ~rst & ~flush_req_i & ~stall_req_i;
    assign imem.pc      = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign state_o      = state_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_req, flush_req;
    logic [31:0]   flush_target;
    logic [31:0]   ifid_pc, ifid_instr;
    logic          ifid_valid, ex_bubble;
    logic [1:0]    state;
    logic [PW-1:0] stall_cnt, flush_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_ctrl_if #(.XLEN(32)) bus ();

    fetch_ctrl #(.XLEN(32), .PERF_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req_i    (stall_req),
        .flush_req_i    (flush_req),
        .flush_target_i (flush_target),
        .imem           (bus),
        .ifid_pc_o      (ifid_pc),
        .ifid_instr_o   (ifid_instr),
        .ifid_valid_o   (ifid_valid),
        .ex_bubble_o    (ex_bubble),
        .state_o        (state),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous IMEM: word at address a is {16'hC0DE, a[15:0]}, data held when not enabled.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_instr <= {16'hC0DE, bus.pc[15:0]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, bus.pc, 32'h0);
        check({tag, "_ifid_v"}, 32'(ifid_valid), 32'h0);
        check({tag, "_ifid_i"}, ifid_instr, 32'h13);
        check({tag, "_ifid_pc"}, ifid_pc, 32'h0);
        check({tag, "_state"}, 32'(state), 32'd2);
        check({tag, "_scnt"}, 32'(stall_cnt), 32'd0);
        check({tag, "_fcnt"}, 32'(flush_cnt), 32'd0);
        check({tag, "_bubble"}, 32'(ex_bubble), 32'd1);
        check({tag, "_en"}, 32'(bus.imem_en), 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall_req = 1'b0; flush_req = 1'b0; flush_target = '0;
        repeat (3) tick();
        check_reset("reset");

        // Reset release and steady fetch
        rst = 1'b0; #1;
        check("rel_en", 32'(bus.imem_en), 32'd1);
        check("rel_bubble", 32'(ex_bubble), 32'd0);
        tick();
        check("c1_ifid_v", 32'(ifid_valid), 32'd0);
        check("c1_pc", bus.pc, 32'h4);
        check("c1_state", 32'(state), 32'd0);
        tick();
        check("c2_ifid_v", 32'(ifid_valid), 32'd1);
        check("c2_ifid_pc", ifid_pc, 32'h0);
        check("c2_ifid_i", ifid_instr, 32'hC0DE_0000);
        check("c2_pc", bus.pc, 32'h8);
        tick();
        check("c3_ifid_pc", ifid_pc, 32'h4);
        check("c3_pc", bus.pc, 32'hC);

        // One-cycle stall with 0x8 in flight
        stall_req = 1'b1; #1;
        check("s1_bubble", 32'(ex_bubble), 32'd1);
        check("s1_en", 32'(bus.imem_en), 32'd0);
        tick();
        check("s1_ifid_hold", ifid_pc, 32'h4);
        check("s1_pc_hold", bus.pc, 32'hC);
        check("s1_scnt", 32'(stall_cnt), 32'd1);
        check("s1_state", 32'(state), 32'd1);
        stall_req = 1'b0; #1;
        check("s1_rel_bubble", 32'(ex_bubble), 32'd0);
        tick();
        check("s1_skid_pc", ifid_pc, 32'h8);
        check("s1_skid_i", ifid_instr, 32'hC0DE_0008);
        check("s1_skid_v", 32'(ifid_valid), 32'd1);
        check("s1_pc_next", bus.pc, 32'h10);
        check("s1_state_run", 32'(state), 32'd0);
        tick();
        check("s1_after_pc", ifid_pc, 32'hC);
        check("s1_after_i", ifid_instr, 32'hC0DE_000C);

        // Three-cycle stall with 0x10 in flight
        stall_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s3_en", 32'(bus.imem_en), 32'd0);
            tick();
            check("s3_ifid_hold", ifid_pc, 32'hC);
            check("s3_pc_hold", bus.pc, 32'h14);
        end
        stall_req = 1'b0;
        tick();
        check("s3_seq0", ifid_pc, 32'h10);
        check("s3_seq0_i", ifid_instr, 32'hC0DE_0010);
        tick();
        check("s3_seq1", ifid_pc, 32'h14);
        tick();
        check("s3_seq2", ifid_pc, 32'h18);
        check("s3_scnt", 32'(stall_cnt), 32'd4);

        // Flush to 0x100
        flush_req = 1'b1; flush_target = 32'h100; #1;
        check("f_bubble", 32'(ex_bubble), 32'd1);
        check("f_en", 32'(bus.imem_en), 32'd0);
        tick();
        check("f_ifid_v", 32'(ifid_valid), 32'd0);
        check("f_ifid_i", ifid_instr, 32'h13);
        check("f_ifid_pc", ifid_pc, 32'h0);
        check("f_pc", bus.pc, 32'h100);
        check("f_state", 32'(state), 32'd2);
        check("f_fcnt", 32'(flush_cnt), 32'd1);
        flush_req = 1'b0;
        tick();
        check("f_c1_v", 32'(ifid_valid), 32'd0);
        check("f_c1_pc", bus.pc, 32'h104);
        tick();
        check("f_c2_pc", ifid_pc, 32'h100);
        check("f_c2_v", 32'(ifid_valid), 32'd1);
        check("f_c2_i", ifid_instr, 32'hC0DE_0100);

        // Stall fills skid, then stall+flush together
        stall_req = 1'b1;
        tick();
        check("sf_scnt0", 32'(stall_cnt), 32'd5);
        flush_req = 1'b1; flush_target = 32'h40;
        tick();
        check("sf_state", 32'(state), 32'd2);
        check("sf_scnt", 32'(stall_cnt), 32'd5);
        check("sf_fcnt", 32'(flush_cnt), 32'd2);
        check("sf_pc", bus.pc, 32'h40);
        stall_req = 1'b0; flush_req = 1'b0;
        tick();
        check("sf_skid_clr", 32'(ifid_valid), 32'd0);
        check("sf_pc_next", bus.pc, 32'h44);
        tick();
        check("sf_tgt_pc", ifid_pc, 32'h40);
        check("sf_tgt_v", 32'(ifid_valid), 32'd1);

        // Back-to-back flushes: only the last target is fetched
        flush_req = 1'b1; flush_target = 32'h200;
        tick();
        flush_target = 32'h300;
        tick();
        check("bb_pc", bus.pc, 32'h300);
        check("bb_fcnt", 32'(flush_cnt), 32'd4);
        flush_req = 1'b0;
        tick();
        tick();
        check("bb_ifid_pc", ifid_pc, 32'h300);
        check("bb_ifid_v", 32'(ifid_valid), 32'd1);

        // Reset during a multi-cycle stall with skid full
        stall_req = 1'b1;
        tick();
        tick();
        check("rs_scnt", 32'(stall_cnt), 32'd7);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0; stall_req = 1'b0;
        tick();
        check("rs_skid_clr", 32'(ifid_valid), 32'd0);
        check("rs_pc", bus.pc, 32'h4);
        tick();
        check("rs_ifid_pc", ifid_pc, 32'h0);
        check("rs_ifid_v", 32'(ifid_valid), 32'd1);

        // PC wrap at the top of the address space
        flush_req = 1'b1; flush_target = 32'hFFFF_FFFC;
        tick();
        flush_req = 1'b0;
        check("wr_pc0", bus.pc, 32'hFFFF_FFFC);
        tick();
        check("wr_pc1", bus.pc, 32'h0);
        tick();
        check("wr_ifid0", ifid_pc, 32'hFFFF_FFFC);
        check("wr_ifid0_i", ifid_instr, 32'hC0DE_FFFC);
        tick();
        check("wr_ifid1", ifid_pc, 32'h0);
        check("wr_ifid1_i", ifid_instr, 32'hC0DE_0000);

        // Counter saturation
        stall_req = 1'b1;
        repeat (260) tick();
        check("sat_scnt", 32'(stall_cnt), 32'hFF);
        stall_req = 1'b0; flush_req = 1'b1;
        repeat (260) tick();
        check("sat_fcnt", 32'(flush_cnt), 32'hFF);
        check("sat_scnt_keep", 32'(stall_cnt), 32'hFF);
        flush_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Front-end pipeline controller that consumes the hazard unit's stall and flush requests.
- Owns the PC register, the synchronous instruction-memory request, a 1-entry fetch skid buffer and the IF/ID register.
- Generates the ID/EX bubble that zeroes rf_we/mem_we of the instruction entering EX.
- Sits between the hazard unit and the IF/ID/EX stages; IMEM read latency is fixed at 1 cycle.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction loaded into IF/ID on bubble (addi x0,x0,0)
PERF_W, 16, width of saturating perf counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall_req_i  in  1  load-use hold request from hazard unit
flush_req_i  in  1  jump/branch redirect request from hazard unit
flush_target_i  in  XLEN  redirect address, valid when flush_req_i=1
imem_en_o  out  1  IMEM read enable this cycle
pc_o  out  XLEN  IMEM read address this cycle
imem_instr_i  in  32  IMEM data for the address issued in the previous cycle
ifid_pc_o  out  XLEN  IF/ID PC
ifid_instr_o  out  32  IF/ID instruction
ifid_valid_o  out  1  IF/ID holds a real instruction
ex_bubble_o  out  1  ID/EX must capture a bubble this cycle
state_o  out  2  current state: RUN=0, STALL=1, REDIR=2
stall_cnt_o  out  PERF_W  cycles with stall accepted (saturating)
flush_cnt_o  out  PERF_W  flushes accepted (saturating)

Behaviour:
- Reset (rst=1 at edge): pc_q=RESET_PC, fetch_vld_q=0, fetch_pc_q=0, skid empty, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, state=REDIR, both counters 0. Reset overrides all inputs, including mid-stall and mid-flush.
- Combinational outputs:
  - ex_bubble_o = rst | flush_req_i | stall_req_i.
  - imem_en_o = !rst & !flush_req_i & !stall_req_i.
  - pc_o = pc_q.
- Priority: flush > stall > run, evaluated every cycle regardless of state.
- RUN/REDIR (no request):
  - Issue pc_q; fetch_pc_q<=pc_q, fetch_vld_q<=1, pc_q<=pc_q+4 (wraps mod 2^XLEN).
  - IF/ID source: skid entry if skid full (skid cleared), else {fetch_pc_q, imem_instr_i, fetch_vld_q}.
  - When the source valid=0, IF/ID loads NOP_INSTR with valid=0.
  - Next state RUN.
- Stall (stall_req_i=1, flush_req_i=0):
  - No issue; pc_q and IF/ID hold.
  - If fetch_vld_q=1 and skid empty, skid <= {fetch_pc_q, imem_instr_i}.
  - fetch_vld_q<=0; next state STALL.
  - Depth 1 is sufficient: at most one response is in flight at stall onset.
- Flush (flush_req_i=1):
  - No issue; pc_q<=flush_target_i; fetch_vld_q<=0; skid cleared.
  - IF/ID <= {0, NOP_INSTR, valid=0}.
  - Next state REDIR.
  - The target is issued in the following cycle; its data reaches IF/ID two cycles after the flush edge.
- Stall release: the first no-request cycle takes IF/ID from the skid and issues the held pc_q. Program order is preserved with no duplicate or lost instruction.
- Simultaneous stall+flush: treated as a flush; the stall counter does not increment.
- Back-to-back flushes: each retargets pc_q; only the last target is fetched.
- Counters:
  - stall_cnt +1 per cycle with stall accepted (flush_req_i=0).
  - flush_cnt +1 per cycle with flush_req_i=1.
  - Both saturate at all-ones.
- flush_target_i is not checked for alignment.

Decomposition:
- Package pipe_pkg: fetch_state_e {RUN, STALL, REDIR}; NOP_INSTR constant; struct fetch_pkt_t {pc, instr, valid}.
- Sub-module fetch_skid: 1-entry buffer with push/pop/clear, full flag, and the fetch_pkt_t payload.

Test Plan:
- Reset release, no requests, IMEM returns mem[addr] -> pc_o 0,4,8,...; first ifid_valid_o=1 two cycles after reset deassert, with ifid_pc_o=0.
- Steady fetch, then stall_req_i=1 for 1 cycle while addr 0x8 is in flight -> skid holds 0x8; next cycle ifid_pc_o=0x8 and pc_o=0xC issued; ex_bubble_o=1 only in the stall cycle; stall_cnt_o=1.
- stall_req_i=1 for 3 cycles -> pc_o and IF/ID stable, imem_en_o=0 for 3 cycles; after release, IF/ID sequence is contiguous (0x4,0x8,0xC, no repeat or skip).
- flush_req_i=1 with target 0x100 during fetch of 0x10 -> IF/ID valid=0 with NOP_INSTR; next cycle pc_o=0x100; ifid_pc_o=0x100 valid two cycles after the flush edge; flush_cnt_o=1.
- stall_req_i=flush_req_i=1 simultaneously, target 0x40 -> flush behaviour, skid cleared, stall_cnt_o unchanged, state_o=REDIR.
- rst asserted during a multi-cycle stall with skid full -> next cycle all outputs at reset values and skid empty; pc_q wrap case: pc 0xFFFF_FFFC -> next 0x0000_0000.
